// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: controller FSM states and the
// buffered entry format {last, data}.
package uart_pkg;

  localparam int RX_DATA_W = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } t_rx_ctrl_fsm;

  typedef struct packed {
    logic                 last;
    logic [RX_DATA_W-1:0] data;
  } t_rx_entry;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers,
// registered occupancy and a one-cycle flush that beats push and pop.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type T_ENTRY = t_rx_entry
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  T_ENTRY                 i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output T_ENTRY                 o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  T_ENTRY        mem_r [DEPTH];
  logic [AW:0]   wptr_r;
  logic [AW:0]   rptr_r;
  logic [AW:0]   level_r;
  logic          empty_s;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pop_ok_s  = i_pop & ~empty_s;
  assign push_ok_s = i_push & (~full_s | pop_ok_s);

  // Pointer and occupancy update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else if (i_flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_ok_s && !i_flush) begin
      mem_r[wptr_r[AW-1:0]] <= i_data;
    end
  end

  // Head entry is masked to zero while empty so idle outputs stay quiet.
  always_comb begin
    if (empty_s) begin
      o_data = '0;
    end else begin
      o_data = mem_r[rptr_r[AW-1:0]];
    end
  end

  assign o_full  = full_s;
  assign o_empty = empty_s;
  assign o_level = level_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: stages bytes from uart_rx, closes frames after a
// line-idle gap, buffers into a FWFT FIFO and counts overruns.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 20,
  parameter int FIFO_DEPTH   = 16,
  parameter int OVF_W        = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_s_axis_tvalid,
  input  logic [RX_DATA_W-1:0]          i_s_axis_tdata,
  input  logic                          i_rxd_busy,
  input  logic                          i_enable,
  input  logic                          i_flush,
  output logic                          o_m_axis_tvalid,
  output logic [RX_DATA_W-1:0]          o_m_axis_tdata,
  output logic                          o_m_axis_tlast,
  input  logic                          i_m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overrun,
  output logic [OVF_W-1:0]              o_overrun_count
);

  localparam int            T      = IDLE_BITS * CLKS_PER_BIT;
  localparam int            TW     = $clog2(T);
  localparam logic [TW-1:0] T_LAST = TW'(T - 1);

  t_rx_ctrl_fsm          state_r;
  logic [RX_DATA_W-1:0]  stage_r;
  logic [TW-1:0]         timer_r;
  logic                  overrun_r;
  logic [OVF_W-1:0]      ovf_cnt_r;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  push_fail_s;
  logic                  full_s;
  logic                  empty_s;
  t_rx_entry             push_entry_s;
  t_rx_entry             head_s;

  // Push decision: a new byte closes the staged one as mid-frame, otherwise
  // the idle timeout closes it as end-of-frame.
  always_comb begin
    accept_s          = i_s_axis_tvalid & i_enable;
    push_s            = 1'b0;
    push_entry_s.last = 1'b0;
    push_entry_s.data = stage_r;
    case (state_r)
      HELD: begin
        if (accept_s) begin
          push_s            = 1'b1;
          push_entry_s.last = 1'b0;
        end else if (timer_r == T_LAST) begin
          push_s            = 1'b1;
          push_entry_s.last = 1'b1;
        end else begin
          push_s            = 1'b0;
          push_entry_s.last = 1'b0;
        end
      end
      EMPTY:   push_s = 1'b0;
      default: push_s = 1'b0;
    endcase
    pop_s       = ~empty_s & i_m_axis_tready;
    push_fail_s = push_s & full_s & ~pop_s;
  end

  // Staging FSM and line-idle timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= EMPTY;
      stage_r <= '0;
      timer_r <= '0;
    end else if (i_flush) begin
      state_r <= EMPTY;
      stage_r <= '0;
      timer_r <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            stage_r <= i_s_axis_tdata;
            timer_r <= '0;
            state_r <= HELD;
          end else begin
            timer_r <= '0;
          end
        end
        HELD: begin
          if (accept_s) begin
            stage_r <= i_s_axis_tdata;
            timer_r <= '0;
          end else if (timer_r == T_LAST) begin
            stage_r <= '0;
            timer_r <= '0;
            state_r <= EMPTY;
          end else if (i_rxd_busy) begin
            timer_r <= '0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r <= EMPTY;
          stage_r <= '0;
          timer_r <= '0;
        end
      endcase
    end
  end

  // Overrun pulse and saturating drop counter; flush leaves the count intact.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_r <= 1'b0;
      ovf_cnt_r <= '0;
    end else if (i_flush) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= push_fail_s;
      if (push_fail_s && (ovf_cnt_r != {OVF_W{1'b1}})) begin
        ovf_cnt_r <= ovf_cnt_r + OVF_W'(1);
      end
    end
  end

  uart_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .T_ENTRY (t_rx_entry)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_data  (push_entry_s),
    .i_pop   (pop_s),
    .i_flush (i_flush),
    .o_data  (head_s),
    .o_full  (full_s),
    .o_empty (empty_s),
    .o_level (o_fifo_level)
  );

  assign o_m_axis_tvalid = ~empty_s;
  assign o_m_axis_tdata  = head_s.data;
  assign o_m_axis_tlast  = head_s.last;
  assign o_overrun       = overrun_r;
  assign o_overrun_count = ovf_cnt_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: framing, idle timeout
// boundary, overrun, flush, reset and enable gating.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int IDLE  = 20;
  localparam int DEPTH = 16;
  localparam int OVF_W = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      s_valid;
  logic [7:0]                s_data;
  logic                      busy;
  logic                      enable;
  logic                      flush;
  logic                      m_ready;
  logic                      m_valid;
  logic [7:0]                m_data;
  logic                      m_last;
  logic [$clog2(DEPTH):0]    level;
  logic                      ovf;
  logic [OVF_W-1:0]          ovf_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ovf_pulses = 0;
  logic [8:0]  got_q [$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .IDLE_BITS    (IDLE),
    .FIFO_DEPTH   (DEPTH),
    .OVF_W        (OVF_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_s_axis_tvalid (s_valid),
    .i_s_axis_tdata  (s_data),
    .i_rxd_busy      (busy),
    .i_enable        (enable),
    .i_flush         (flush),
    .o_m_axis_tvalid (m_valid),
    .o_m_axis_tdata  (m_data),
    .o_m_axis_tlast  (m_last),
    .i_m_axis_tready (m_ready),
    .o_fifo_level    (level),
    .o_overrun       (ovf),
    .o_overrun_count (ovf_cnt)
  );

  // Output-side monitor: records every handshake and every overrun pulse.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (!rst && ovf) ovf_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  // uart_rx model: busy for a whole 10-bit character, strobe in its last cycle.
  task automatic uart_byte(input logic [7:0] d);
    busy = 1'b1;
    repeat (CPB*10 - 1) tick();
    strobe(d);
    busy = 1'b0;
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    else return 32'hDEAD;
  endfunction

  initial begin
    int base;
    int lat;
    int p0;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; busy = 1'b0;
    enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 32'(m_valid), 32'd0);
    check("rst_tdata",  32'(m_data),  32'd0);
    check("rst_tlast",  32'(m_last),  32'd0);
    check("rst_level",  32'(level),   32'd0);
    check("rst_ovf",    32'(ovf),     32'd0);
    check("rst_cnt",    32'(ovf_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1;
    tick();

    // Three bytes then idle; tlast after 320 non-busy cycles.
    m_ready = 1'b1;
    base = got_q.size();
    uart_byte(8'h11); uart_byte(8'h22); uart_byte(8'h33);
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (m_valid && m_last) begin
        lat = c;
        break;
      end
    end
    check("t1_latency", 32'(lat), 32'd320);
    repeat (3) tick();
    check("t1_count", 32'(got_q.size()), 32'(base + 3));
    check("t1_b0", q_at(base),     32'h011);
    check("t1_b1", q_at(base + 1), 32'h022);
    check("t1_b2", q_at(base + 2), 32'h133);

    // Two frames separated by a 25-bit idle gap.
    base = got_q.size();
    uart_byte(8'hA5);
    repeat (25*CPB) tick();
    uart_byte(8'h5A); uart_byte(8'hC3);
    repeat (400) tick();
    check("t2_count", 32'(got_q.size()), 32'(base + 3));
    check("t2_b0", q_at(base),     32'h1A5);
    check("t2_b1", q_at(base + 1), 32'h05A);
    check("t2_b2", q_at(base + 2), 32'h1C3);

    // 20 back-to-back bytes into a stalled consumer.
    m_ready = 1'b0;
    p0 = ovf_pulses;
    base = got_q.size();
    for (int i = 0; i < 20; i++) strobe(8'h40 + 8'(i));
    repeat (3) tick();
    check("t3_level",  32'(level), 32'd16);
    check("t3_pulses", 32'(ovf_pulses - p0), 32'd3);
    check("t3_cnt",    32'(ovf_cnt), 32'd3);
    check("t3_tvalid", 32'(m_valid), 32'd1);
    check("t3_head",   32'(m_data), 32'h40);
    m_ready = 1'b1;
    repeat (20) tick();
    check("t3_drained", 32'(got_q.size()), 32'(base + 16));
    for (int i = 0; i < 16; i++)
      check($sformatf("t3_b%0d", i), q_at(base + i), 32'h040 + 32'(i));
    repeat (320) tick();
    check("t3_tail", q_at(base + 16), 32'h153);
    check("t3_level0", 32'(level), 32'd0);

    // Byte in the exact timeout cycle wins: frame stays open.
    base = got_q.size();
    strobe(8'h77);
    repeat (319) tick();
    strobe(8'h88);
    repeat (3) tick();
    check("t4a_count", 32'(got_q.size()), 32'(base + 1));
    check("t4a_b0",    q_at(base), 32'h077);
    check("t4a_open",  32'(m_valid), 32'd0);
    repeat (330) tick();
    check("t4a_b1",    q_at(base + 1), 32'h188);

    // One cycle later the timeout closes the frame first.
    base = got_q.size();
    strobe(8'h99);
    repeat (320) tick();
    strobe(8'hAA);
    repeat (3) tick();
    check("t4b_count", 32'(got_q.size()), 32'(base + 1));
    check("t4b_b0",    q_at(base), 32'h199);
    repeat (330) tick();
    check("t4b_b1",    q_at(base + 1), 32'h1AA);

    // Flush with 5 queued and one staged.
    m_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 6; i++) strobe(8'hB0 + 8'(i));
    repeat (2) tick();
    check("t5_level_pre", 32'(level), 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_level",  32'(level), 32'd0);
    check("t5_tvalid", 32'(m_valid), 32'd0);
    check("t5_cnt",    32'(ovf_cnt), 32'd3);
    m_ready = 1'b1;
    repeat (400) tick();
    check("t5_nothing", 32'(got_q.size()), 32'(base));

    // Async reset mid-frame.
    m_ready = 1'b0;
    strobe(8'hC1); strobe(8'hC2);
    tick();
    check("t6_level_pre", 32'(level), 32'd1);
    rst = 1'b1;
    #2;
    check("t6_tvalid", 32'(m_valid), 32'd0);
    check("t6_tdata",  32'(m_data),  32'd0);
    check("t6_tlast",  32'(m_last),  32'd0);
    check("t6_level",  32'(level),   32'd0);
    check("t6_ovf",    32'(ovf),     32'd0);
    check("t6_cnt",    32'(ovf_cnt), 32'd0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    base = got_q.size();
    repeat (400) tick();
    check("t6_nothing", 32'(got_q.size()), 32'(base));

    // Disabled strobes ignored; pending timeout still closes the frame.
    base = got_q.size();
    strobe(8'h3C);
    enable = 1'b0;
    strobe(8'hDE); strobe(8'hAD);
    repeat (400) tick();
    enable = 1'b1;
    check("t7_count", 32'(got_q.size()), 32'(base + 1));
    check("t7_b0",    q_at(base), 32'h13C);
    check("t7_cnt",   32'(ovf_cnt), 32'd0);
    check("t7_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-path controller between `uart_rx` and a downstream AXI-Stream byte consumer. It adds backpressure buffering to the receiver's unthrottled output and packetises bytes into frames, asserting `tlast` after a programmable line-idle gap. It also detects and counts FIFO overruns, and lets software enable, disable or flush the receive path.

## Interface
- `CLKS_PER_BIT`, 16, UART bit period in `i_clk` cycles; must match `uart_rx`.
- `IDLE_BITS`, 20, idle bit-times that close a frame; timeout `T = IDLE_BITS*CLKS_PER_BIT` cycles.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 4.
- `OVF_W`, 8, overrun counter width.

- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_s_axis_tvalid`  in  1  byte strobe from `uart_rx`; one cycle; no tready.
- `i_s_axis_tdata`  in  8  received byte.
- `i_rxd_busy`  in  1  `uart_rx` busy status.
- `i_enable`  in  1  0 = incoming strobes ignored.
- `i_flush`  in  1  one-cycle synchronous clear of the buffered path.
- `o_m_axis_tvalid`  out  1  output byte valid.
- `o_m_axis_tdata`  out  8  output byte.
- `o_m_axis_tlast`  out  1  last byte of frame.
- `i_m_axis_tready`  in  1  consumer ready.
- `o_fifo_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `o_overrun`  out  1  one-cycle pulse per dropped byte.
- `o_overrun_count`  out  OVF_W  dropped bytes, saturating at all-ones.

## Operation
- Reset values: all outputs 0; FSM `EMPTY`; FIFO empty; staging register and idle timer cleared.
- The newest byte waits in a staging register until its `last` flag is known. The FIFO stores 9-bit entries `{last, data}`.
- An accepted byte is a cycle with `i_s_axis_tvalid & i_enable`.
- FSM state `EMPTY`: staging is invalid.
  - On an accepted byte: stage it, clear the timer, go to `HELD`.
- FSM state `HELD`: staging is valid.
  - The timer increments while `i_rxd_busy == 0` and clears while `i_rxd_busy == 1`.
  - On an accepted byte: push the staged byte with `last = 0`, stage the new byte, clear the timer, stay in `HELD`.
  - When the timer reaches `T-1`: push the staged byte with `last = 1`, go to `EMPTY`.
  - If a byte is accepted in the same cycle the timer reaches `T-1`, the byte wins: push with `last = 0` and stay in `HELD`.
- Push rule: the push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped, `o_overrun` pulses, and the counter increments (saturating).
  - A dropped `last = 1` entry loses that frame boundary. This is accepted behaviour.
- Pop happens on `o_m_axis_tvalid & i_m_axis_tready`.
- `i_enable = 0` does not stop a pending timeout; the staged byte is still flushed out with `last = 1`.
- `i_flush` clears the FIFO, staging and timer, and forces `EMPTY`.
  - Flush beats any simultaneous push or pop in that cycle.
  - `o_overrun_count` is kept; only `i_rst` clears it.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally. Full = MSBs differ and remaining bits equal.

## Timing
- `o_m_axis_tvalid = !empty`. Data and last come from the read-pointer entry (first-word fall-through).
- An entry pushed in cycle N is visible at the output in cycle N+1.
- Byte strobe in cycle N is staged in N+1. It is pushed no earlier than the next byte, or after T idle cycles.
- AXIS rules: `tdata`/`tlast` stay stable while `tvalid & !tready`. `tvalid` never drops without a pop or flush.
- `o_fifo_level` is registered and updates one cycle after each push or pop.
- Async reset can occur mid-frame: all state is lost immediately and no partial frame is emitted.

## Structure
- Package `uart_pkg` holds:
  - `t_rx_ctrl_fsm` enum {`EMPTY`, `HELD`};
  - `t_rx_entry` packed struct {`last`, `data[7:0]`}.
- Sub-module `uart_fifo`: synchronous FWFT FIFO.
  - Parameters: `DEPTH`, entry type.
  - Signals: push/pop/flush, full/empty/level.
  - Async active-high reset.

## Test plan
- Bytes 0x11, 0x22, 0x33 from a `uart_rx` model at 16 clk/bit, then idle → output 0x11/L0, 0x22/L0, 0x33/L1. `tlast` appears 320 non-busy cycles after the final busy falls.
- Two frames {0xA5} and {0x5A, 0xC3} separated by a 25-bit gap, with tready=1 → 0xA5/L1, 0x5A/L0, 0xC3/L1.
- tready=0, 20 bytes back to back (depth 16) → 16 entries held, `o_fifo_level` = 16. Three further `o_overrun` pulses, count = 3. Releasing tready drains the first 16 bytes in order.
- Byte strobe forced in the same cycle the timer reaches T-1 → staged byte pushed with L0, new byte staged, frame stays open.
- `i_flush` with 5 entries queued and staging valid → level 0 next cycle, tvalid 0, overrun count unchanged.
- `i_rst` pulsed mid-frame, and `i_enable = 0` during 2 bytes → all outputs 0 after reset; disabled bytes never appear and are not counted.
